// File: rtl/fu_result_buffer_if.sv
// Producer-side bundle between one FU pipeline, its result buffer and the
// complete stage. The buffer takes the slave view; the FU/complete side
// (or a bench standing in for both) takes the master view.
interface fu_result_buffer_if #(
    parameter int XLEN  = 32,
    parameter int PR_W  = 6,
    parameter int ROB_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [PR_W-1:0]  in_dest_pr;
    logic [XLEN-1:0]  in_dest_value;
    logic [ROB_W-1:0] in_rob_entry;
    logic             in_if_take_branch;
    logic [XLEN-1:0]  in_target_pc;
    logic             in_halt;
    logic             fu_finish;
    logic             fu_c_stall;
    logic             out_valid;
    logic [PR_W-1:0]  out_dest_pr;
    logic [XLEN-1:0]  out_dest_value;
    logic [ROB_W-1:0] out_rob_entry;
    logic             out_if_take_branch;
    logic [XLEN-1:0]  out_target_pc;
    logic             out_halt;

    modport master (
        output flush, in_valid, in_dest_pr, in_dest_value, in_rob_entry,
               in_if_take_branch, in_target_pc, in_halt, fu_c_stall,
        input  in_ready, fu_finish, out_valid, out_dest_pr, out_dest_value,
               out_rob_entry, out_if_take_branch, out_target_pc, out_halt
    );

    modport slave (
        input  flush, in_valid, in_dest_pr, in_dest_value, in_rob_entry,
               in_if_take_branch, in_target_pc, in_halt, fu_c_stall,
        output in_ready, fu_finish, out_valid, out_dest_pr, out_dest_value,
               out_rob_entry, out_if_take_branch, out_target_pc, out_halt
    );
endinterface

// File: rtl/fu_result_buffer.sv
// Per-FU result FIFO feeding the complete stage. Requests completion from
// registered occupancy only, pops on grant and presents the granted packet
// on the FU's complete slot for exactly one cycle.
module fu_result_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int PR_W  = 6,
    parameter int ROB_W = 5
) (
    input logic              clock,
    input logic              reset,
    fu_result_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [PR_W-1:0]  dest_pr;
        logic [XLEN-1:0]  dest_value;
        logic [ROB_W-1:0] rob_entry;
        logic             if_take_branch;
        logic [XLEN-1:0]  target_pc;
        logic             halt;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           out_q;
    logic             out_valid_q;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             grant;
    logic             in_ready;
    logic             fu_finish;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake terms come only from registered state, so stall never
    // combinationally feeds back into in_ready.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign fu_finish = (count != '0);
    assign push      = bus.in_valid && in_ready;
    assign grant     = fu_finish && !bus.fu_c_stall;

    assign in_entry = '{
        dest_pr:        bus.in_dest_pr,
        dest_value:     bus.in_dest_value,
        rob_entry:      bus.in_rob_entry,
        if_take_branch: bus.in_if_take_branch,
        target_pc:      bus.in_target_pc,
        halt:           bus.in_halt
    };

    // Entry storage; contents are don't-care while not counted, so no reset.
    always_ff @(posedge clock) begin
        if (push && !bus.flush) mem[tail] <= in_entry;
    end

    // Pointers and occupancy; flush squashes any same-edge push/grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)  tail <= wrap_inc(tail);
            if (grant) head <= wrap_inc(head);
            case ({push, grant})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Complete slot: head entry for one cycle after a grant, zeros otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.flush || !grant) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= 1'b1;
            out_q       <= mem[head];
        end
    end

    assign bus.in_ready           = in_ready;
    assign bus.fu_finish          = fu_finish;
    assign bus.out_valid          = out_valid_q;
    assign bus.out_dest_pr        = out_q.dest_pr;
    assign bus.out_dest_value     = out_q.dest_value;
    assign bus.out_rob_entry      = out_q.rob_entry;
    assign bus.out_if_take_branch = out_q.if_take_branch;
    assign bus.out_target_pc      = out_q.target_pc;
    assign bus.out_halt           = out_q.halt;
endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: directed vector table, a mid-cycle reset
// sequence and a randomized run against a queue-based reference model.
module tb_fu_result_buffer;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int PR_W  = 6;
    localparam int ROB_W = 5;

    typedef struct packed {
        logic [PR_W-1:0]  pr;
        logic [XLEN-1:0]  val;
        logic [ROB_W-1:0] rob;
        logic             tb;
        logic [XLEN-1:0]  pc;
        logic             h;
    } pkt_t;

    typedef struct {
        logic fl, iv, st;
        pkt_t in;
        logic rdy, fin, ov;
        pkt_t out;
    } vec_t;

    logic clock;
    logic reset;
    int   errs;
    int   checks;
    vec_t vecs[$];
    pkt_t Z;

    fu_result_buffer_if #(.XLEN(XLEN), .PR_W(PR_W), .ROB_W(ROB_W)) bus ();

    fu_result_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .PR_W(PR_W), .ROB_W(ROB_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic pkt_t pk(input logic [PR_W-1:0] pr, input logic [XLEN-1:0] val,
                                input logic [ROB_W-1:0] rob, input logic tb,
                                input logic [XLEN-1:0] pc, input logic h);
        pkt_t p;
        p.pr = pr; p.val = val; p.rob = rob; p.tb = tb; p.pc = pc; p.h = h;
        return p;
    endfunction

    function automatic pkt_t cur_out();
        return pk(bus.out_dest_pr, bus.out_dest_value, bus.out_rob_entry,
                  bus.out_if_take_branch, bus.out_target_pc, bus.out_halt);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic st, input pkt_t p);
        bus.flush             = fl;
        bus.in_valid          = iv;
        bus.fu_c_stall        = st;
        bus.in_dest_pr        = p.pr;
        bus.in_dest_value     = p.val;
        bus.in_rob_entry      = p.rob;
        bus.in_if_take_branch = p.tb;
        bus.in_target_pc      = p.pc;
        bus.in_halt           = p.h;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic fl, input logic iv, input logic st, input pkt_t in,
                       input logic rdy, input logic fin, input logic ov, input pkt_t out);
        vec_t v;
        v.fl = fl; v.iv = iv; v.st = st; v.in = in;
        v.rdy = rdy; v.fin = fin; v.ov = ov; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic fin,
                             input logic ov, input pkt_t out);
        chk({tag, " in_ready"},  128'(bus.in_ready),  128'(rdy));
        chk({tag, " fu_finish"}, 128'(bus.fu_finish), 128'(fin));
        chk({tag, " out_valid"}, 128'(bus.out_valid), 128'(ov));
        chk({tag, " out_pkt"},   128'(cur_out()),     128'(out));
    endtask

    // Reference model state
    pkt_t m_q[$];
    logic m_ov;
    pkt_t m_out;

    initial begin
        pkt_t A, B, A2, B2, C, D, E, F, G, H, p;
        logic fl, iv, st, rdy, fin, grant;
        errs = 0;
        checks = 0;
        Z = '0;

        A  = pk(6'd5,  32'hDEAD_BEEF, 5'd3, 1'b0, 32'h0, 1'b0);
        B  = pk(6'd7,  32'h1111_1111, 5'd4, 1'b0, 32'h0, 1'b0);
        A2 = pk(6'd1,  32'h0000_000A, 5'd1, 1'b0, 32'h0, 1'b0);
        B2 = pk(6'd2,  32'h0000_000B, 5'd2, 1'b0, 32'h0, 1'b0);
        C  = pk(6'd3,  32'h0000_000C, 5'd3, 1'b0, 32'h0, 1'b0);
        D  = pk(6'd9,  32'h0000_0055, 5'd6, 1'b1, 32'h0000_1040, 1'b0);
        E  = pk(6'd10, 32'h0000_0001, 5'd7, 1'b0, 32'h0, 1'b0);
        F  = pk(6'd11, 32'h0000_0002, 5'd8, 1'b1, 32'h2000, 1'b0);
        G  = pk(6'd12, 32'h0000_0003, 5'd9, 1'b0, 32'h0, 1'b0);
        H  = pk(6'd63, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0, 1'b1);

        // fl iv st  in    rdy fin ov out   (expected after the edge)
        add(0, 1, 0, A,  1, 1, 0, Z);   // single result
        add(0, 0, 0, Z,  1, 0, 1, A);
        add(0, 0, 0, Z,  1, 0, 0, Z);
        add(0, 1, 1, B,  1, 1, 0, Z);   // stall hold
        add(0, 0, 1, Z,  1, 1, 0, Z);
        add(0, 0, 1, Z,  1, 1, 0, Z);
        add(0, 0, 1, Z,  1, 1, 0, Z);
        add(0, 0, 0, Z,  1, 0, 1, B);
        add(0, 0, 0, Z,  1, 0, 0, Z);
        add(0, 1, 1, A2, 1, 1, 0, Z);   // fill while stalled
        add(0, 1, 1, B2, 0, 1, 0, Z);
        add(0, 1, 0, C,  1, 1, 1, A2);  // full: C refused, A2 granted
        add(0, 1, 0, C,  1, 1, 1, B2);  // push C with grant B2
        add(0, 0, 0, Z,  1, 0, 1, C);
        add(0, 0, 0, Z,  1, 0, 0, Z);
        add(0, 1, 0, D,  1, 1, 0, Z);   // branch fields
        add(0, 0, 0, Z,  1, 0, 1, D);
        add(0, 0, 0, Z,  1, 0, 0, Z);
        add(0, 1, 1, E,  1, 1, 0, Z);   // flush with grant and push
        add(0, 1, 1, F,  0, 1, 0, Z);
        add(1, 1, 0, G,  1, 0, 0, Z);
        add(0, 0, 0, Z,  1, 0, 0, Z);
        add(0, 1, 0, H,  1, 1, 0, Z);   // extreme field values
        add(0, 0, 0, Z,  1, 0, 1, H);

        drive(0, 0, 0, Z);
        reset = 1'b0;
        #12;
        check_all("reset", 1'b1, 1'b0, 1'b0, Z);
        @(negedge clock);
        reset = 1'b1;
        cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].st, vecs[i].in);
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].fin, vecs[i].ov, vecs[i].out);
        end

        // Mid-cycle asynchronous reset with two queued entries
        drive(0, 1, 1, A); cycle();
        drive(0, 1, 1, B); cycle();
        chk("prereset full", 128'(bus.in_ready), 128'(0));
        drive(0, 0, 0, Z);
        #2 reset = 1'b0;
        #1 check_all("async_reset", 1'b1, 1'b0, 1'b0, Z);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all($sformatf("postreset%0d", i), 1'b1, 1'b0, 1'b0, Z);
        end
        drive(0, 1, 0, C); cycle();
        check_all("postreset push", 1'b1, 1'b1, 1'b0, Z);
        drive(0, 0, 0, Z); cycle();
        check_all("postreset grant", 1'b1, 1'b0, 1'b1, C);

        // Randomized run against the queue model; start from a flush
        drive(1, 0, 0, Z); cycle();
        m_q.delete();
        m_ov = 1'b0;
        m_out = '0;
        for (int n = 0; n < 3000; n++) begin
            fl = ($urandom_range(0, 39) == 0);
            iv = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 9) < 4);
            p  = pk(PR_W'($urandom), $urandom, ROB_W'($urandom), 1'($urandom),
                    $urandom, 1'($urandom));
            drive(fl, iv, st, p);
            rdy   = (m_q.size() < DEPTH);
            fin   = (m_q.size() != 0);
            grant = fin && !st;
            if (fl) begin
                m_q.delete();
                m_ov  = 1'b0;
                m_out = '0;
            end else begin
                if (grant) begin
                    m_ov  = 1'b1;
                    m_out = m_q.pop_front();
                end else begin
                    m_ov  = 1'b0;
                    m_out = '0;
                end
                if (iv && rdy) m_q.push_back(p);
            end
            cycle();
            check_all($sformatf("rand%0d", n), (m_q.size() < DEPTH), (m_q.size() != 0), m_ov, m_out);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fu_result_buffer.md
# fu_result_buffer

Per-functional-unit result queue on the producer side of the complete-stage arbitration interface. It accepts finished results from one FU pipeline and holds them while the complete stage stalls that FU. It raises the FU's `fu_finish` bit, and on the cycle after a grant it drives the granted packet onto that FU's `fu_c_in` slot. One instance sits between each of the eight FUs (alu_1 … branch) and the complete stage.

## Interface
Parameters:
- `DEPTH`, 2: result entries held, must be ≥ 1.
- `XLEN`, 32: data and PC width.
- `PR_W`, 6: physical-register tag width.
- `ROB_W`, 5: ROB index width (matches `` `ROB ``).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `flush` in 1: synchronous squash on precise-state recovery.
- `in_valid` in 1: FU presents a finished result this cycle.
- `in_ready` out 1: buffer accepts the result at this edge.
- `in_dest_pr` in PR_W: result fields from the FU.
- `in_dest_value` in XLEN: result fields from the FU.
- `in_rob_entry` in ROB_W: result fields from the FU.
- `in_if_take_branch` in 1: result fields from the FU.
- `in_target_pc` in XLEN: result fields from the FU.
- `in_halt` in 1: result fields from the FU.
- `fu_finish` out 1: request to complete, this FU's bit of `FU_STATE_PACKET`.
- `fu_c_stall` in 1: this FU's stall bit from the complete stage, driven combinationally.
- `out_valid`, `out_dest_pr`, `out_dest_value`, `out_rob_entry`, `out_if_take_branch`, `out_target_pc`, `out_halt` out: this FU's `FU_COMPLETE_PACKET` slot.

## Operation
- Storage is a circular FIFO of `DEPTH` entries with head and tail pointers that wrap modulo `DEPTH`.
- The occupancy counter is `$clog2(DEPTH+1)` bits wide.
- Push: `in_valid && in_ready` at an edge writes the tail entry.
- `in_ready` = (count < DEPTH) and depends only on registered state, never on `fu_c_stall`.
- Request: `fu_finish` = (count != 0). It is driven only from registered state, so an empty buffer never requests in the same cycle it is written.
- Grant: `fu_finish && !fu_c_stall` at an edge. On a grant:
  - the head entry is popped;
  - the head entry is loaded into the output register with `out_valid` = 1.
- Any edge without a grant loads the output register with all zeros. The output is therefore valid for exactly one cycle per grant, matching the complete stage's registered selection.
- Push and grant at the same edge: count is unchanged; both pointers advance.
  - A push is legal when full only if `in_ready`, so a full buffer with a simultaneous grant still refuses the push.
- Stall: with `fu_c_stall` = 1 the head is held and `fu_finish` stays high. Entries never reorder or drop.
- `flush` at an edge has priority over push and grant:
  - count ← 0 and both pointers ← 0;
  - the output register ← zeros;
  - any push or grant at that edge is discarded.
- Reset (`reset` = 0, asynchronous) yields this state:
  - count, pointers and output register are 0;
  - `fu_finish` = 0 and `in_ready` = 1;
  - every `out_*` field is 0.
- If reset asserts mid-operation, all queued and granted results are lost. Operation restarts on the first edge after `reset` returns to 1.

## Timing
- Push at edge k → `fu_finish` = 1 during cycle k+1.
- The earliest grant is at edge k+1, giving packet on `out_*` during cycle k+1 → k+2, i.e. a minimum 2-edge latency from FU result to complete slot.
- Back-to-back grants at consecutive edges give one valid packet per cycle. With two or more queued entries `fu_finish` stays high throughout.
- With `DEPTH` ≥ 2, throughput is one result per cycle when never stalled. With `DEPTH` = 1, one result every 2 cycles.
- `fu_c_stall` is sampled only at the edge; it is ignored while `fu_finish` = 0.

## Test plan
- **Reset:**
  - Stimulus: hold `reset` = 0 mid-cycle with 2 entries queued.
  - Required: all outputs 0 immediately and `in_ready` = 1; after release, `fu_finish` stays 0 until a push.
- **Single result:**
  - Stimulus: push `{pr=5, value=32'hDEAD_BEEF, rob=3}` at edge 1 with `fu_c_stall` = 0.
  - Required: `fu_finish` = 1 in cycle 1–2; `out_valid` = 1 with those fields in cycle 2–3, then all zero.
- **Stall hold:**
  - Stimulus: push A, then hold `fu_c_stall` = 1 for 3 edges, then release.
  - Required: `fu_finish` stays 1 throughout and `out_valid` stays 0; A appears exactly once, the cycle after the release edge.
- **Full and simultaneous push/grant:**
  - Stimulus: with `DEPTH` = 2, push A, B while stalled; then present C.
  - Required: `in_ready` = 0 and C is held back by the FU. At the grant edge A moves to out; the next edge accepts C. Output order is A, B, C in consecutive cycles.
- **Flush:**
  - Stimulus: 2 entries queued; assert `flush` together with a grant and a push.
  - Required: next cycle count = 0, `fu_finish` = 0, `out_*` = 0, and no packet is emitted.
- **Branch fields:**
  - Stimulus: push `{if_take_branch=1, target_pc=32'h0000_1040, halt=0}`.
  - Required: `out_if_take_branch` = 1 and `out_target_pc` = 0x1040 only in the post-grant cycle.
